// File: rtl/fader_sched_pkg.sv
// Shared types and constants for the fader run scheduler.
package fader_sched_pack;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StRun,
    StDrain
  } state_e;

  localparam int unsigned DEF_M   = 8;
  localparam int unsigned DEF_N   = 32;
  localparam int unsigned RUN_LEN = DEF_M * DEF_N;
  localparam int unsigned CNT_W   = 9;
  localparam int unsigned T_W     = 25;

endpackage

// File: rtl/fader_sched_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/fader_sched.sv
// Schedules one fader run per sample tick: START pulse, M*N RUN cycles, PIPE_LAT DRAIN cycles,
// then advances the time index. Ticks arriving while a run is in flight are counted as overruns.
module fader_sched
  import fader_sched_pack::*;
#(
  parameter int unsigned M        = DEF_M,
  parameter int unsigned N        = DEF_N,
  parameter int unsigned PIPE_LAT = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  input  logic           tick,
  input  logic           t_load,
  input  logic [T_W-1:0] t_load_val,
  input  logic           clr_overrun,
  output logic           fader_start,
  output logic [T_W-1:0] fader_t_index,
  output logic           busy,
  output logic           run_done,
  output logic           overrun,
  output logic [15:0]    overrun_count
);

  localparam int unsigned     RunLen    = M * N;
  localparam logic [CNT_W-1:0] RunLast   = CNT_W'(RunLen - 1);
  localparam logic [CNT_W-1:0] DrainLast = CNT_W'(PIPE_LAT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [T_W-1:0]   idx_q, idx_d;
  logic [T_W-1:0]   pend_val_q, pend_val_d;
  logic             pend_q, pend_d;
  logic             overrun_q, overrun_d;
  logic             busy_w, done_w, drop_w;

  assign busy_w = (state_q != StIdle);
  assign done_w = (state_q == StDrain) && (cnt_q == DrainLast);
  assign drop_w = tick && busy_w;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (tick && enable) begin
          state_d = StStart;
        end
      end
      StStart: begin
        state_d = StRun;
        cnt_d   = '0;
      end
      StRun: begin
        if (cnt_q == RunLast) begin
          state_d = StDrain;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDrain: begin
        if (cnt_q == DrainLast) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Index is frozen while busy; loads arriving mid-run are parked until run_done.
  // A load on the run_done cycle itself is the freshest value and wins.
  always_comb begin
    idx_d      = idx_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    if (done_w) begin
      pend_d = 1'b0;
      if (t_load) begin
        idx_d = t_load_val;
      end else if (pend_q) begin
        idx_d = pend_val_q;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else if (t_load) begin
      if (busy_w) begin
        pend_d     = 1'b1;
        pend_val_d = t_load_val;
      end else begin
        idx_d = t_load_val;
      end
    end
  end

  always_comb begin
    overrun_d = overrun_q;
    if (clr_overrun) begin
      overrun_d = 1'b0;
    end else if (drop_w) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      overrun_q  <= overrun_d;
    end
  end

  sat_counter #(
    .Width(16)
  ) u_overrun_cnt (
    .clk_i  (clk),
    .rst_ni (reset),
    .clr_i  (clr_overrun),
    .inc_i  (drop_w),
    .count_o(overrun_count)
  );

  assign fader_start   = (state_q == StStart);
  assign fader_t_index = idx_q;
  assign busy          = busy_w;
  assign run_done      = done_w;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_fader_sched.sv
// Self-checking bench for fader_sched against a run-window reference model.
module tb_fader_sched;

  localparam int L = 1 + 8 * 32 + 4;

  logic        clk = 1'b0;
  logic        reset, enable, tick, t_load, clr_overrun;
  logic [24:0] t_load_val;
  logic        fader_start, busy, run_done, overrun;
  logic [24:0] fader_t_index;
  logic [15:0] overrun_count;

  int total = 0;
  int bad   = 0;

  // Model: a run occupies windows [m_s, m_s+L-1]; window = interval after a rising edge.
  int          m_w;
  int          m_s;
  logic [24:0] m_idx, m_pv;
  bit          m_pend, m_ovf;
  logic [15:0] m_cnt;

  fader_sched dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .tick         (tick),
    .t_load       (t_load),
    .t_load_val   (t_load_val),
    .clr_overrun  (clr_overrun),
    .fader_start  (fader_start),
    .fader_t_index(fader_t_index),
    .busy         (busy),
    .run_done     (run_done),
    .overrun      (overrun),
    .overrun_count(overrun_count)
  );

  always #5 clk = ~clk;

  function automatic bit m_busy();
    return (m_w >= m_s) && (m_w <= m_s + L - 1);
  endfunction

  function automatic bit m_start();
    return m_w == m_s;
  endfunction

  function automatic bit m_done();
    return m_w == m_s + L - 1;
  endfunction

  task automatic model_reset();
    m_s    = -1000000;
    m_idx  = '0;
    m_pv   = '0;
    m_pend = 1'b0;
    m_ovf  = 1'b0;
    m_cnt  = '0;
  endtask

  task automatic model_update(input bit tk, input bit en, input bit tl, input logic [24:0] v,
                              input bit cl);
    bit b, d, ev;
    b  = m_busy();
    d  = m_done();
    ev = tk && b;
    if (d) begin
      m_idx  = tl ? v : (m_pend ? m_pv : m_idx + 25'd1);
      m_pend = 1'b0;
    end else if (tl && b) begin
      m_pend = 1'b1;
      m_pv   = v;
    end else if (tl) begin
      m_idx = v;
    end
    if (tk && !b && en) m_s = m_w + 1;
    if (cl) begin
      m_ovf = 1'b0;
      m_cnt = '0;
    end else if (ev) begin
      m_ovf = 1'b1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
  endtask

  // Drive one window of inputs, advance the model, land #1 after the next rising edge.
  task automatic step(input bit tk, input bit en, input bit tl, input logic [24:0] v,
                      input bit cl);
    tick        = tk;
    enable      = en;
    t_load      = tl;
    t_load_val  = v;
    clr_overrun = cl;
    if (reset) model_update(tk, en, tl, v, cl);
    else model_reset();
    m_w++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; tick = 1'b0; t_load = 1'b0; t_load_val = '0;
    clr_overrun = 1'b0;
    model_reset();
    m_w = 0;
    #2;
    total++;
    if ({busy, fader_start, run_done, overrun, overrun_count, fader_t_index} !== 45'd0) begin
      bad++;
      $display("FAIL reset_state: got %h want 0",
               {busy, fader_start, run_done, overrun, overrun_count, fader_t_index});
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(0, 1, 0, 0, 0);
  endtask

  task automatic test_basic();
    int n = 1;
    step(1, 1, 0, 0, 0);
    total++;
    if (fader_start !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_start: got start=%b busy=%b want 1 1", fader_start, busy);
    end
    step(0, 1, 0, 0, 0);
    n++;
    total++;
    if (fader_start !== 1'b0) begin
      bad++;
      $display("FAIL basic_start_width: got %b want 0", fader_start);
    end
    while (run_done !== 1'b1 && n < 400) begin
      step(0, 1, 0, 0, 0);
      n++;
    end
    total++;
    if (n != 261) begin
      bad++;
      $display("FAIL basic_run_len: got %0d want 261", n);
    end
    total++;
    if (fader_t_index !== 25'd0) begin
      bad++;
      $display("FAIL basic_idx_hold: got %h want 0", fader_t_index);
    end
    step(0, 1, 0, 0, 0);
    total++;
    if (fader_t_index !== 25'd1 || busy !== 1'b0 || run_done !== 1'b0) begin
      bad++;
      $display("FAIL basic_idx_inc: got idx=%h busy=%b want 1 0", fader_t_index, busy);
    end
  endtask

  task automatic test_load_tick();
    int n = 0;
    step(1, 1, 1, 25'h0ABCDE, 0);
    total++;
    if (fader_start !== 1'b1 || fader_t_index !== 25'h0ABCDE) begin
      bad++;
      $display("FAIL load_tick: got start=%b idx=%h want 1 0abcde", fader_start, fader_t_index);
    end
    while (busy === 1'b1 && n < 400) begin
      step(0, 1, 0, 0, 0);
      n++;
    end
    total++;
    if (fader_t_index !== 25'h0ABCDF) begin
      bad++;
      $display("FAIL load_tick_after: got %h want 0abcdf", fader_t_index);
    end
  endtask

  task automatic test_wrap();
    int n = 1;
    step(0, 1, 1, 25'h1FFFFFF, 0);
    total++;
    if (fader_t_index !== 25'h1FFFFFF) begin
      bad++;
      $display("FAIL wrap_load: got %h want 1ffffff", fader_t_index);
    end
    step(1, 1, 0, 0, 0);
    while (run_done !== 1'b1 && n < 400) begin
      step(0, 1, 0, 0, 0);
      n++;
    end
    total++;
    if (fader_t_index !== 25'h1FFFFFF || n != 261) begin
      bad++;
      $display("FAIL wrap_during: got idx=%h len=%0d want 1ffffff 261", fader_t_index, n);
    end
    step(0, 1, 0, 0, 0);
    total++;
    if (fader_t_index !== 25'd0) begin
      bad++;
      $display("FAIL wrap_after: got %h want 0", fader_t_index);
    end
  endtask

  task automatic test_pending();
    int n = 1;
    step(1, 1, 0, 0, 0);
    while (run_done !== 1'b1 && n < 400) begin
      step(0, 1, (n == 50) || (n == 258), (n == 50) ? 25'h100 : 25'h200, 0);
      n++;
      if (n == 51 && fader_t_index !== 25'd0) begin
        total++;
        bad++;
        $display("FAIL pending_hold: got %h want 0", fader_t_index);
      end
    end
    step(0, 1, 0, 0, 0);
    total++;
    if (fader_t_index !== 25'h200) begin
      bad++;
      $display("FAIL pending_apply: got %h want 200", fader_t_index);
    end
  endtask

  task automatic test_overrun();
    int n = 1;
    step(0, 1, 0, 0, 1);
    step(1, 1, 0, 0, 0);
    while (run_done !== 1'b1 && n < 400) begin
      step(n == 101, 1, 0, 0, 0);
      n++;
    end
    total++;
    if (n != 261) begin
      bad++;
      $display("FAIL overrun_run_len: got %0d want 261", n);
    end
    step(1, 1, 0, 0, 0);
    total++;
    if (overrun !== 1'b1 || overrun_count !== 16'd2 || busy !== 1'b0) begin
      bad++;
      $display("FAIL overrun_count: got ovf=%b cnt=%0d busy=%b want 1 2 0",
               overrun, overrun_count, busy);
    end
  endtask

  task automatic test_enable_drop();
    int n = 1;
    step(1, 1, 0, 0, 0);
    while (run_done !== 1'b1 && n < 400) begin
      step(0, 0, 0, 0, 0);
      n++;
    end
    total++;
    if (n != 261) begin
      bad++;
      $display("FAIL enable_drop_len: got %0d want 261", n);
    end
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    total++;
    if (busy !== 1'b0 || overrun_count !== m_cnt) begin
      bad++;
      $display("FAIL enable_drop_ignore: got busy=%b cnt=%0d want 0 %0d", busy, overrun_count,
               m_cnt);
    end
  endtask

  task automatic test_mid_reset();
    int n = 1;
    bit seen = 1'b0;
    step(1, 1, 0, 0, 0);
    while (n < 51) begin
      step(0, 1, 0, 0, 0);
      n++;
    end
    reset = 1'b0;
    model_reset();
    #1;
    total++;
    if ({busy, fader_start, run_done, overrun, overrun_count, fader_t_index} !== 45'd0) begin
      bad++;
      $display("FAIL mid_reset_clear: got %h want 0",
               {busy, fader_start, run_done, overrun, overrun_count, fader_t_index});
    end
    repeat (300) begin
      step(1, 1, 0, 0, 0);
      if (run_done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL mid_reset_no_done: got activity=1 want 0");
    end
    reset = 1'b1;
    #1;
    step(1, 1, 0, 0, 0);
    total++;
    if (fader_start !== 1'b1 || fader_t_index !== 25'd0) begin
      bad++;
      $display("FAIL mid_reset_restart: got start=%b idx=%h want 1 0", fader_start, fader_t_index);
    end
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      step(0, 1, 0, 0, 0);
      n++;
    end
  endtask

  task automatic test_random();
    logic [44:0] got, want;
    for (int i = 0; i < 1500; i++) begin
      got  = {busy, fader_start, run_done, overrun, overrun_count, fader_t_index};
      want = {m_busy(), m_start(), m_done(), m_ovf, m_cnt, m_idx};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL random_w%0d: got %h want %h", i, got, want);
      end
      step($urandom_range(0, 39) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 59) == 0,
           25'($urandom), $urandom_range(0, 199) == 0);
    end
  endtask

  task automatic test_saturate();
    int n = 0;
    repeat (70000) step(1, 1, 0, 0, 0);
    total++;
    if (overrun_count !== 16'hFFFF || overrun !== 1'b1 || m_cnt !== 16'hFFFF) begin
      bad++;
      $display("FAIL saturate: got cnt=%h ovf=%b want ffff 1", overrun_count, overrun);
    end
    if (busy !== 1'b1) step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 1);
    total++;
    if (overrun_count !== 16'd0 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL clr_precedence: got cnt=%h ovf=%b want 0 0", overrun_count, overrun);
    end
    while (busy === 1'b1 && n < 400) begin
      step(0, 1, 0, 0, 0);
      n++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL saturate_drain: got busy=%b want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_load_tick();
    test_wrap();
    test_pending();
    test_overrun();
    test_enable_drop();
    test_mid_reset();
    test_random();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
